inert_spi_resp: RTL and testbench
=================================

// Module: inert_spi_resp
// PURPOSE
//  SPI responder modelling the inertial sensor side of the 16-bit mode-0 SPI link driven by inert_intf/SPI_mstr16.
//  Decodes 16-bit frames: cmd[15]=1 read, cmd[15]=0 write; addr=cmd[14:8]; wdata=cmd[7:0].
//  Holds the four config registers, snapshots pitch-rate/AZ samples every ODR period and raises INT.
//  Synthesizable; used as the sensor stand-in for FPGA bring-up and in full-chip benches.
// PARAMETERS
//  ODR_CYC   50000   clk cycles per output-data-rate tick (>=64)
//  WHO_AM_I  8'h6A   value returned on a read of addr 0x0F
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  SS_n        in   1   SPI select, active low (async to clk)
//  SCLK        in   1   SPI clock, idle low (async to clk)
//  MOSI        in   1   SPI data in, MSB first
//  ptch_rt_in  in   16  live pitch-rate sample (signed)
//  AZ_in       in   16  live Z-accel sample (signed)
//  MISO        out  1   SPI data out, MSB first
//  INT         out  1   data-ready interrupt, active high
// BEHAVIOUR
//  Reset: MISO=0, INT=0, all registers 0x00, snapshot 0, bit count 0, ODR counter 0.
//  Sync: SS_n/SCLK/MOSI each double-flopped; 3rd flop on SS_n/SCLK for edge detect. SCLK half-period >= 4 clk required.
//  Frame: synced SS_n fall clears bit count and shift regs. Synced SCLK rise: rx_shft <= {rx_shft[14:0],MOSI_s}, cnt++ (saturates at 16).
//  MISO: = tx_shft[7] while SS_n low, 0 while SS_n high (no tristate).
//   On synced SCLK fall with cnt==8 and rx_shft[7]=1: tx_shft <= rd_mux(rx_shft[6:0]); later falls (cnt 9..15) shift tx_shft left.
//   Bits 15..8 of the frame return 0 on MISO.
//  Frame end: synced SS_n rise with cnt==16 commits; cnt!=16 aborts (no write, no INT clear, no state change).
//  Write commit: addr 0x0D->INT_CFG, 0x10->CTRL1, 0x11->CTRL2, 0x14->CTRL6; other addresses ignored.
//  Read map: 0x0D/0x10/0x11/0x14 read back, 0x0F WHO_AM_I, 0x22 snap_ptch[7:0], 0x23 snap_ptch[15:8],
//   0x2C snap_AZ[7:0], 0x2D snap_AZ[15:8], all others 0x00.
//  ODR: counter 0..ODR_CYC-1 free-running, tick at ODR_CYC-1 then wraps to 0.
//   int_en = INT_CFG[1] (0x02 enables DRDY on INT).
//   On tick with int_en and (INT==0 or clr_int same cycle): snapshot <= {ptch_rt_in, AZ_in}; INT <= 1 next clk.
//   On tick with INT==1 and no clr_int: sample dropped, snapshot unchanged (coherent burst).
//   clr_int: committed read frame of addr 0x2D -> INT <= 0 next clk, unless a tick loads a new sample that cycle (INT stays 1).
//   Writing INT_CFG[1]=0 clears INT next clk; snapshot retained.
//  Latency: INT rises 1 clk after tick; falls 1 clk after synced SS_n rise of the 0x2D read.
//  Reset mid-frame: everything returns to reset values; a partial frame is lost.
//  Back-to-back frames (SS_n high >= 4 clk) are supported.
// STRUCTURE
//  inert_pkg: localparams for register addresses (REG_INT_CFG=7'h0D, REG_CTRL1=7'h10, REG_CTRL2=7'h11,
//   REG_CTRL6=7'h14, REG_WHO=7'h0F, REG_PTCH_L=7'h22 .. REG_AZ_H=7'h2D) and typedef spi_frame_t (rd, addr[6:0], data[7:0]);
//   shared with inert_intf.
//  Sub-module spi_slv16: synchronizers, edge detect, rx/tx shifters, bit count.
//   Outputs: frame_done, frame (spi_frame_t), rd_addr_vld, rd_addr. Input: rd_data[7:0].
//   Top holds the register file, rd_mux, ODR counter, snapshot and INT logic.
// TESTING (ODR_CYC=200 in bench; drive with SPI_mstr16)
//  1 Init: write 0x0D02,0x1053,0x1150,0x1460 -> regs read back 02/53/50/60; INT rises 1 clk after the first tick.
//  2 ID: frame 0x8F00 -> MISO returns 0x6A in low byte; INT unchanged.
//  3 Burst: ptch_rt_in=16'hF3A5, AZ_in=16'h0123 at tick; reads A200,A300,AC00,AD00 -> A5,F3,23,01; INT low 1 clk after last SS_n rise.
//  4 Coherency: change inputs and let 2 ticks pass mid-burst (INT high) -> burst still returns F3A5/0123; next tick after clear loads new values.
//  5 Abort: SS_n high after 10 SCLKs of 0x1000 -> CTRL1 stays 0x53; aborted 0xAD00 after 12 bits -> INT stays 1.
//  6 Reset mid-frame: rst_n low for 2 clk during bit 6 -> MISO=0, INT=0, regs 0; next full frame 0x8F00 -> 0x6A.

Source files
------------

// File: rtl/inert_pkg.sv
// Shared definitions for the inertial-sensor SPI link: register map and frame layout.
package inert_pkg;

    // Register addresses (7-bit address field of a 16-bit frame)
    localparam logic [6:0] REG_INT_CFG = 7'h0D;
    localparam logic [6:0] REG_WHO     = 7'h0F;
    localparam logic [6:0] REG_CTRL1   = 7'h10;
    localparam logic [6:0] REG_CTRL2   = 7'h11;
    localparam logic [6:0] REG_CTRL6   = 7'h14;
    localparam logic [6:0] REG_PTCH_L  = 7'h22;
    localparam logic [6:0] REG_PTCH_H  = 7'h23;
    localparam logic [6:0] REG_AZ_L    = 7'h2C;
    localparam logic [6:0] REG_AZ_H    = 7'h2D;

    // Bit count value that marks a complete frame; the counter saturates here
    localparam logic [4:0] CNT_FULL = 5'd16;
    // Bit count at which the command byte has been fully received
    localparam logic [4:0] CNT_CMD  = 5'd8;

    // One 16-bit SPI frame as seen on MOSI, MSB first
    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
    } spi_frame_t;

endpackage

// File: rtl/inert_spi_resp_spi_slv16.sv
// 16-bit mode-0 SPI slave front end: synchronizers, edge detect, rx/tx shifters, bit count.
module spi_slv16
    import inert_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic [7:0]       rd_data,
    output logic             MISO,
    output logic             frame_done,
    output spi_frame_t       frame,
    output logic             rd_addr_vld,
    output logic [6:0]       rd_addr
);

    logic [2:0]  ss_sync;
    logic [2:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic [15:0] rx_shft;
    logic [7:0]  tx_shft;
    logic [4:0]  cnt;

    logic ss_s, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    assign ss_s      = ss_sync[1];
    assign ss_fall   = ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    assign mosi_s    = mosi_sync[1];

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: select synchronizer resets to the idle (high) level so reset never fakes a frame start
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge value of its neighbour
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    // Shift MOSI in on SCLK rise, load/shift the response byte on SCLK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shft <= '0;
            tx_shft <= '0;
            cnt     <= '0;
        end else if (ss_fall) begin
            rx_shft <= '0;
            tx_shft <= '0;
            cnt     <= '0;
        end else begin
            if (sclk_rise) begin
                rx_shft <= {rx_shft[14:0], mosi_s};
                if (cnt != CNT_FULL) cnt <= cnt + 5'd1;
            end
            if (sclk_fall) begin
                if (rd_addr_vld)
                    tx_shft <= rd_data;
                else if (cnt > CNT_CMD && cnt < CNT_FULL)
                    tx_shft <= {tx_shft[6:0], 1'b0};
            end
        end
    end

    assign rd_addr_vld = (cnt == CNT_CMD) & rx_shft[7];
    assign rd_addr     = rx_shft[6:0];
    assign frame       = spi_frame_t'(rx_shft);
    assign frame_done  = ss_rise & (cnt == CNT_FULL);
    assign MISO        = ~ss_s & tx_shft[7];

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial sensor SPI responder: config registers, read mux, ODR timer, sample snapshot and INT.
module inert_spi_resp
    import inert_pkg::*;
#(
    parameter int         ODR_CYC  = 50000,
    parameter logic [7:0] WHO_AM_I = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [15:0] ptch_rt_in,
    input  logic [15:0] AZ_in,
    output logic        MISO,
    output logic        INT
);

    localparam int CW = $clog2(ODR_CYC);

    logic             frame_done, rd_addr_vld;
    spi_frame_t       frame;
    logic [6:0]       rd_addr;
    logic [7:0]       rd_data;

    logic [7:0]       int_cfg, ctrl1, ctrl2, ctrl6;
    logic [15:0]      snap_ptch, snap_az;
    logic [CW-1:0]    odr_cnt;
    logic             int_q;
    logic             tick, wr_cmt, clr_int, dis_clr, load;

    spi_slv16 u_spi (
        .clk         (clk),
        .rst_n       (rst_n),
        .SS_n        (SS_n),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .rd_data     (rd_data),
        .MISO        (MISO),
        .frame_done  (frame_done),
        .frame       (frame),
        .rd_addr_vld (rd_addr_vld),
        .rd_addr     (rd_addr)
    );

    assign tick    = (odr_cnt == CW'(ODR_CYC - 1));
    assign wr_cmt  = frame_done & ~frame.rd;
    assign clr_int = frame_done & frame.rd & (frame.addr == REG_AZ_H);
    assign dis_clr = wr_cmt & (frame.addr == REG_INT_CFG) & ~frame.data[1];
    // A new sample is taken only when the previous one has been consumed (or is being consumed now)
    assign load    = tick & int_cfg[1] & (~int_q | clr_int);

    // Free-running output-data-rate counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    odr_cnt <= '0;
        else if (tick) odr_cnt <= '0;
        else           odr_cnt <= odr_cnt + CW'(1);
    end

    // Config register writes on a committed write frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cfg <= '0;
            ctrl1   <= '0;
            ctrl2   <= '0;
            ctrl6   <= '0;
        end else if (wr_cmt) begin
            case (frame.addr)
                REG_INT_CFG: int_cfg <= frame.data;
                REG_CTRL1:   ctrl1   <= frame.data;
                REG_CTRL2:   ctrl2   <= frame.data;
                REG_CTRL6:   ctrl6   <= frame.data;
                default:     ;
            endcase
        end
    end

    // Snapshot capture and data-ready interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_ptch <= '0;
            snap_az   <= '0;
            int_q     <= 1'b0;
        end else if (dis_clr) begin
            int_q <= 1'b0;
        end else if (load) begin
            snap_ptch <= ptch_rt_in;
            snap_az   <= AZ_in;
            int_q     <= 1'b1;
        end else if (clr_int) begin
            int_q <= 1'b0;
        end
    end

    // Read mux feeding the response byte
    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch is inferred
        rd_data = 8'h00;
        if (rd_addr_vld) begin
            case (rd_addr)
                REG_INT_CFG: rd_data = int_cfg;
                REG_CTRL1:   rd_data = ctrl1;
                REG_CTRL2:   rd_data = ctrl2;
                REG_CTRL6:   rd_data = ctrl6;
                REG_WHO:     rd_data = WHO_AM_I;
                REG_PTCH_L:  rd_data = snap_ptch[7:0];
                REG_PTCH_H:  rd_data = snap_ptch[15:8];
                REG_AZ_L:    rd_data = snap_az[7:0];
                REG_AZ_H:    rd_data = snap_az[15:8];
                default:     rd_data = 8'h00;
            endcase
        end
    end

    assign INT = int_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Self-checking bench for inert_spi_resp: SPI master task, register/snapshot/INT reference model.
module tb_inert_spi_resp;

    localparam int ODR  = 200;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic [15:0] ptch_rt_in = 16'h0000;
    logic [15:0] AZ_in = 16'h0000;
    logic        MISO;
    logic        INT;

    inert_spi_resp #(.ODR_CYC(ODR), .WHO_AM_I(8'h6A)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .ptch_rt_in (ptch_rt_in),
        .AZ_in      (AZ_in),
        .MISO       (MISO),
        .INT        (INT)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_reg [0:127];
    logic [31:0] m_snap;
    logic        m_int;
    int          cyc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            if (n_errors < 50) $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
        m_snap = 32'h0;
        m_int  = 1'b0;
    endtask

    function automatic logic [7:0] exp_rd(input logic [6:0] a);
        case (a)
            7'h0D, 7'h10, 7'h11, 7'h14: return m_reg[a];
            7'h0F: return 8'h6A;
            7'h22: return m_snap[23:16];
            7'h23: return m_snap[31:24];
            7'h2C: return m_snap[7:0];
            7'h2D: return m_snap[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_commit(input logic [15:0] cmd);
        logic [6:0] a;
        a = cmd[14:8];
        if (cmd[15]) begin
            if (a == 7'h2D) m_int = 1'b0;
        end else begin
            if (a == 7'h0D || a == 7'h10 || a == 7'h11 || a == 7'h14) m_reg[a] = cmd[7:0];
            if (a == 7'h0D && !cmd[1]) m_int = 1'b0;
        end
    endtask

    // ODR model: cycle count since reset release, sample taken every ODR cycles
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            cyc = 0;
        end else begin
            cyc = cyc + 1;
            if (cyc % ODR == 0 && m_reg[13][1] && !m_int) begin
                m_snap = {ptch_rt_in, AZ_in};
                m_int  = 1'b1;
            end
        end
    end

    // INT tracks the model on every cycle
    initial forever begin
        @(negedge clk);
        if (rst_n) check("int_track", {31'b0, INT}, {31'b0, m_int});
    end

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_miso", {31'b0, MISO}, 32'h0);
        check("rst_int", {31'b0, INT}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Mode-0 SPI master; nbits<16 aborts, rst_bit>=0 pulses reset after that SCLK rise
    task automatic spi_xfer(input string tag, input logic [15:0] cmd, input int nbits,
                            input int rst_bit, output logic [15:0] rx);
        logic [7:0] exp;
        rx = 16'h0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[15-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[14:0], MISO};
            SCLK = 1'b1;
            if (i == rst_bit) pulse_reset();
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        // keep the commit cycle clear of an ODR tick
        for (int k = 0; k < 40 && ((cyc % ODR) >= ODR - 15 || (cyc % ODR) <= 3); k++)
            @(negedge clk);
        exp = exp_rd(cmd[14:8]);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check({tag, "_int_pre"}, {31'b0, INT}, {31'b0, m_int});
        @(posedge clk);
        #2;
        if (nbits == 16 && rst_bit < 0) begin
            model_commit(cmd);
            check({tag, "_data"}, {16'h0, rx}, cmd[15] ? {24'h0, exp} : 32'h0);
        end
        check({tag, "_int_post"}, {31'b0, INT}, {31'b0, m_int});
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cyc(input int r);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * ODR && !found; k++) begin
            @(posedge clk);
            #2;
            if (cyc % ODR == r) found = 1'b1;
        end
        check("wait_cyc", {31'b0, found}, 32'h1);
    endtask

    task automatic burst(input string tag, input logic [31:0] want);
        logic [15:0] rx;
        spi_xfer({tag, "_pl"}, 16'hA200, 16, -1, rx); check({tag, "_pl_c"}, {16'h0, rx}, {24'h0, want[23:16]});
        spi_xfer({tag, "_ph"}, 16'hA300, 16, -1, rx); check({tag, "_ph_c"}, {16'h0, rx}, {24'h0, want[31:24]});
        spi_xfer({tag, "_al"}, 16'hAC00, 16, -1, rx); check({tag, "_al_c"}, {16'h0, rx}, {24'h0, want[7:0]});
        spi_xfer({tag, "_ah"}, 16'hAD00, 16, -1, rx); check({tag, "_ah_c"}, {16'h0, rx}, {24'h0, want[15:8]});
    endtask

    initial begin
        logic [15:0] rx;
        logic [31:0] v1, v2;
        logic [6:0]  a;
        logic [15:0] cmd;

        model_reset();
        cyc = 0;
        ptch_rt_in = 16'hF3A5;
        AZ_in      = 16'h0123;
        repeat (3) @(negedge clk);
        check("reset_miso", {31'b0, MISO}, 32'h0);
        check("reset_int", {31'b0, INT}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_int", {31'b0, INT}, 32'h0);

        // 1: init writes, INT rise one clk after the first enabled tick
        spi_xfer("wr_intcfg", 16'h0D02, 16, -1, rx);
        wait_cyc(ODR - 1);
        check("int_before_tick", {31'b0, INT}, 32'h0);
        @(posedge clk);
        #2;
        check("int_rise", {31'b0, INT}, 32'h1);
        spi_xfer("wr_ctrl1", 16'h1053, 16, -1, rx);
        spi_xfer("wr_ctrl2", 16'h1150, 16, -1, rx);
        spi_xfer("wr_ctrl6", 16'h1460, 16, -1, rx);
        spi_xfer("rd_intcfg", 16'h8D00, 16, -1, rx); check("intcfg_c", {16'h0, rx}, 32'h02);
        spi_xfer("rd_ctrl1", 16'h9000, 16, -1, rx);  check("ctrl1_c", {16'h0, rx}, 32'h53);
        spi_xfer("rd_ctrl2", 16'h9100, 16, -1, rx);  check("ctrl2_c", {16'h0, rx}, 32'h50);
        spi_xfer("rd_ctrl6", 16'h9400, 16, -1, rx);  check("ctrl6_c", {16'h0, rx}, 32'h60);

        // 2: identity
        spi_xfer("who", 16'h8F00, 16, -1, rx);
        check("who_c", {16'h0, rx}, 32'h6A);
        check("who_int", {31'b0, INT}, 32'h1);

        // 3: coherent burst of the first sample
        burst("b1", 32'hF3A5_0123);
        check("b1_int_low", {31'b0, INT}, 32'h0);

        // 4: samples arriving while INT is high are dropped
        v1 = $urandom;
        ptch_rt_in = v1[31:16];
        AZ_in      = v1[15:0];
        wait_cyc(0);
        v2 = $urandom;
        ptch_rt_in = v2[31:16];
        AZ_in      = v2[15:0];
        wait_cyc(0);
        wait_cyc(0);
        burst("b2", v1);
        wait_cyc(0);
        check("b3_int_high", {31'b0, INT}, 32'h1);
        burst("b3", v2);

        // 5: aborted frames change nothing
        wait_cyc(0);
        spi_xfer("abort_wr", 16'h1000, 10, -1, rx);
        spi_xfer("rd_ctrl1_ab", 16'h9000, 16, -1, rx);
        check("ctrl1_kept", {16'h0, rx}, 32'h53);
        spi_xfer("abort_rd", 16'hAD00, 12, -1, rx);
        check("abort_int_kept", {31'b0, INT}, 32'h1);

        // random register traffic against the model
        for (int n = 0; n < 8; n++) begin
            a = 7'($urandom_range(0, 127));
            if (a == 7'h22 || a == 7'h23 || a == 7'h2C || a == 7'h2D) a = 7'h11;
            cmd = {1'($urandom), a, 8'($urandom)};
            if (!cmd[15] && a == 7'h0D) cmd[14:8] = 7'h14;
            spi_xfer("rnd", cmd, 16, -1, rx);
        end

        // 6: reset during bit 6 of a frame
        spi_xfer("rst_frame", 16'h8F00, 16, 5, rx);
        check("after_rst_int", {31'b0, INT}, 32'h0);
        spi_xfer("rst_intcfg", 16'h8D00, 16, -1, rx); check("rst_intcfg_c", {16'h0, rx}, 32'h00);
        spi_xfer("rst_ctrl1", 16'h9000, 16, -1, rx);  check("rst_ctrl1_c", {16'h0, rx}, 32'h00);
        spi_xfer("rst_ctrl6", 16'h9400, 16, -1, rx);  check("rst_ctrl6_c", {16'h0, rx}, 32'h00);
        spi_xfer("rst_ptch", 16'hA300, 16, -1, rx);   check("rst_snap_c", {16'h0, rx}, 32'h00);
        spi_xfer("who2", 16'h8F00, 16, -1, rx);       check("who2_c", {16'h0, rx}, 32'h6A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
